// File: rtl/rr_mux16_pkg.sv
// Shared constants and types for the round-robin mux16 arbiter.
package rr_mux16_pkg;
    localparam int NREQ   = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/mux16.sv
// 16:1 single-bit selector driven by the arbiter select.
module mux16 (
    input  logic [15:0] din,
    input  logic [3:0]  sel,
    output logic        dout
);
    assign dout = din[sel];
endmodule

// File: rtl/rr_pick16.sv
// Rotating-priority picker: first requester at or after ptr, wrapping,
// optionally skipping one masked index.
import rr_mux16_pkg::*;

module rr_pick16 (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] mask_idx,
    input  logic             use_mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand] && !(use_mask && cand == mask_idx)) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin owner of the mux16 select with a per-grant hold limit
// and a registered data bit.
import rr_mux16_pkg::*;

module rr_mux16_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  din,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             dout_valid
);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              dout_q, dout_vld_q;

    logic [SEL_W-1:0]  pick_ptr, pick_idx;
    logic              pick_found, busy, mux_bit;

    assign busy     = (state_q == BUSY);
    // In BUSY the search always restarts just past the owner.
    assign pick_ptr = busy ? owner_q + 4'd1 : ptr_q;

    rr_pick16 u_pick (
        .req      (req),
        .mask_idx (owner_q),
        .use_mask (busy),
        .ptr      (pick_ptr),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    mux16 u_mux (
        .din  (din),
        .sel  (sel_q),
        .dout (mux_bit)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    sel_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    hold_d  = 4'd1;
                end
            end
            BUSY: begin
                if (!req[owner_q] || (hold_q == HOLD_MAX && pick_found)) begin
                    ptr_d = owner_q + 4'd1;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        sel_d   = pick_idx;
                        gnt_d   = NREQ'(1) << pick_idx;
                        hold_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            sel_q      <= '0;
            hold_q     <= '0;
            gnt_q      <= '0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            gnt_q      <= gnt_d;
            dout_q     <= gnt_valid ? mux_bit : 1'b0;
            dout_vld_q <= gnt_valid;
        end
    end

    assign gnt        = gnt_q;
    assign gnt_valid  = |gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_vld_q;
endmodule
